// File: rtl/mem_writer_if.sv
// Command and memory-write bus of mem_writer; slave is the writer, master drives commands.
// No latency or backpressure of its own: pure wiring between writer and its user.
// Flow control is the cmd_valid/cmd_ready handshake carried here.
interface mem_writer_if #(
    parameter int width = 16,
    parameter int asize = 11
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_fill;
    logic [asize-1:0] cmd_addr;
    logic [asize:0]   cmd_len;
    logic [width-1:0] cmd_data;
    logic             abort;
    logic             we;
    logic [asize-1:0] waddr;
    logic [width-1:0] wdata;
    logic             busy;
    logic             done;

    modport slave (
        input  cmd_valid, cmd_fill, cmd_addr, cmd_len, cmd_data, abort,
        output cmd_ready, we, waddr, wdata, busy, done
    );

    modport master (
        output cmd_valid, cmd_fill, cmd_addr, cmd_len, cmd_data, abort,
        input  cmd_ready, we, waddr, wdata, busy, done
    );
endinterface

// File: rtl/mem_writer.sv
// Memory writer: one-word write or fill run of a latched value from a start address.
// Latency: first write the cycle after acceptance, done one cycle after the last write.
// Backpressure: cmd_ready only in IDLE; one command in flight at a time.
module mem_writer #(
    parameter int size  = 2048,
    parameter int width = 16,
    parameter int asize = $clog2(size)
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_writer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

    localparam logic [asize:0]   SIZE_L    = (asize+1)'(size);
    localparam logic [asize-1:0] LAST_ADDR = asize'(size - 1);
    localparam logic [asize:0]   ONE_L     = (asize+1)'(1);

    state_t           r_state;
    state_t           w_next;
    logic [asize-1:0] r_waddr;
    logic [width-1:0] r_wdata;
    logic [asize:0]   r_rem;

    logic             w_accept;
    logic [asize:0]   w_len;
    logic             w_fill_end;
    logic [asize-1:0] w_addr_inc;
    logic             w_ready;
    logic             w_we;
    logic             w_busy;
    logic             w_done;

    assign w_accept   = bus.cmd_valid && (r_state == IDLE);
    assign w_len      = (bus.cmd_len > SIZE_L) ? SIZE_L : bus.cmd_len;
    assign w_fill_end = (r_rem == ONE_L) || bus.abort;
    // Explicit wrap so non-power-of-2 memories roll over at size-1.
    assign w_addr_inc = (r_waddr == LAST_ADDR) ? '0 : r_waddr + asize'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
                if (w_accept) begin
                    if (!bus.cmd_fill)         w_next = WRITE;
                    else if (w_len == '0)      w_next = DONE;
                    else                       w_next = FILL;
                end
            end
            WRITE: begin
                w_we   = 1'b1;
                w_next = DONE;
            end
            FILL: begin
                w_we = 1'b1;
                if (w_fill_end) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Write address/data registers only load when a write will follow, so they
    // keep showing the last written word whenever we is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_wdata <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (!bus.cmd_fill || w_len != '0)) begin
                        r_waddr <= bus.cmd_addr;
                        r_wdata <= bus.cmd_data;
                        r_rem   <= bus.cmd_fill ? w_len : ONE_L;
                    end
                end
                WRITE: r_rem <= '0;
                FILL: begin
                    if (w_fill_end) begin
                        r_rem <= '0;
                    end else begin
                        r_rem   <= r_rem - ONE_L;
                        r_waddr <= w_addr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = w_ready && rst_n;
    assign bus.we        = w_we;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.waddr     = r_waddr;
    assign bus.wdata     = r_wdata;
endmodule

// File: tb/tb_mem_writer.sv
// Bench for mem_writer: command table plus hand sequences for back-to-back and reset mid-fill.
// Expected writes go to a scoreboard queue when a command is driven; a monitor pops on each we.
module tb_mem_writer;
    localparam int SIZE  = 2048;
    localparam int WIDTH = 16;
    localparam int ASIZE = 11;
    localparam int LIMIT = 2200;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit          fill;
        int          addr;
        int          len;
        logic [15:0] data;
        int          abort_at;
        int          exp_nw;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_writer_if #(.width(WIDTH), .asize(ASIZE)) bus ();

    mem_writer #(.size(SIZE), .width(WIDTH), .asize(ASIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    wr_t         sb_q[$];
    wr_t         mon_e;
    logic [31:0] last_addr = 0;
    logic [31:0] last_data = 0;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.we) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", bus.waddr, bus.wdata);
            end else begin
                mon_e = sb_q.pop_front();
                check("write_addr", 32'(bus.waddr), mon_e.addr);
                check("write_data", 32'(bus.wdata), mon_e.data);
            end
        end
        if (rst_n && bus.done) done_cnt++;
    end

    task automatic push_writes(input int addr, input int n, input logic [15:0] data);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{32'((addr + i) % SIZE), 32'(data)});
            last_addr = 32'((addr + i) % SIZE);
            last_data = 32'(data);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".ready_wait"}, 32'(k < 100), 32'd1);
    endtask

    task automatic scramble();
        bus.cmd_fill = 1'($urandom);
        bus.cmd_addr = ASIZE'($urandom);
        bus.cmd_len  = (ASIZE+1)'($urandom);
        bus.cmd_data = WIDTH'($urandom);
    endtask

    task automatic run_cmd(input bit fill, input int addr, input int len, input logic [15:0] data,
                           input int abort_at, input int exp_nw, input string tag);
        int done_k;
        push_writes(addr, exp_nw, data);
        wait_ready(tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_fill  = fill;
        bus.cmd_addr  = ASIZE'(addr);
        bus.cmd_len   = (ASIZE+1)'(len);
        bus.cmd_data  = data;
        bus.abort     = (abort_at == 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        scramble();
        bus.abort = (abort_at == 1);
        done_k = -1;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_k = k;
                break;
            end
            check({tag, ".busy"}, 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
            bus.abort = (abort_at == k + 1);
        end
        check({tag, ".done_cycle"}, 32'(done_k), 32'(exp_nw + 1));
        check({tag, ".done_we"}, 32'(bus.we), 32'd0);
        bus.abort = 1'b0;
        @(negedge clk);
        check({tag, ".ready_after"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, ".done_once"}, 32'(bus.done), 32'd0);
        check({tag, ".waddr_hold"}, 32'(bus.waddr), last_addr);
        check({tag, ".wdata_hold"}, 32'(bus.wdata), last_data);
        check({tag, ".sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".we"},    32'(bus.we),        32'd0);
        check({tag, ".busy"},  32'(bus.busy),      32'd0);
        check({tag, ".done"},  32'(bus.done),      32'd0);
        check({tag, ".ready"}, 32'(bus.cmd_ready), 32'd0);
        check({tag, ".waddr"}, 32'(bus.waddr),     32'd0);
        check({tag, ".wdata"}, 32'(bus.wdata),     32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dsave;
        int k;
        bus.cmd_valid = 1'b0;
        bus.cmd_fill  = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        bus.abort     = 1'b0;

        //          fill  addr  len   data      abort  writes
        vecs[0] = '{1'b0, 5,    1,    16'hABCD, -1,    1};
        vecs[1] = '{1'b1, 2046, 4,    16'h0F0F, -1,    4};
        vecs[2] = '{1'b1, 300,  0,    16'h1234, -1,    0};
        vecs[3] = '{1'b1, 0,    100,  16'h5A5A, 3,     3};
        vecs[4] = '{1'b1, 2047, 1,    16'hFFFF, -1,    1};
        vecs[5] = '{1'b0, 2047, 9,    16'h0001, 1,     1};
        vecs[6] = '{1'b1, 20,   3,    16'h8000, 0,     3};
        vecs[7] = '{1'b1, 40,   0,    16'h4444, 1,     0};
        vecs[8] = '{1'b1, 100,  4095, 16'hC3C3, -1,    2048};
        vecs[9] = '{1'b1, 600,  5,    16'h9999, 1,     1};

        #2;
        check_reset_outputs("rst_async");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_clocked");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release.ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_release.busy",  32'(bus.busy),      32'd0);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].fill, vecs[i].addr, vecs[i].len, vecs[i].data,
                    vecs[i].abort_at, vecs[i].exp_nw, $sformatf("vec%0d", i));
        end

        // Back-to-back: valid stays high, second command must wait for IDLE.
        push_writes(500, 3, 16'h1111);
        push_writes(9, 1, 16'h2222);
        wait_ready("b2b");
        bus.cmd_valid = 1'b1;
        bus.cmd_fill  = 1'b1;
        bus.cmd_addr  = ASIZE'(500);
        bus.cmd_len   = (ASIZE+1)'(3);
        bus.cmd_data  = 16'h1111;
        @(posedge clk); #1;
        bus.cmd_fill  = 1'b0;
        bus.cmd_addr  = ASIZE'(9);
        bus.cmd_data  = 16'h2222;
        k = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            check("b2b.ready_low", 32'(bus.cmd_ready), 32'd0);
            if (bus.done === 1'b1) begin
                k = j;
                break;
            end
        end
        check("b2b.a_done_cycle", 32'(k), 32'd4);
        @(negedge clk);
        check("b2b.ready_after_a", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        k = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                k = j;
                break;
            end
        end
        check("b2b.b_done_cycle", 32'(k), 32'd2);
        @(negedge clk);
        check("b2b.sb_empty", 32'(sb_q.size()), 32'd0);
        check("b2b.waddr_hold", 32'(bus.waddr), 32'd9);

        // Reset after five writes of a 50-word fill.
        push_writes(10, 5, 16'h3C3C);
        wait_ready("rstfill");
        bus.cmd_valid = 1'b1;
        bus.cmd_fill  = 1'b1;
        bus.cmd_addr  = ASIZE'(10);
        bus.cmd_len   = (ASIZE+1)'(50);
        bus.cmd_data  = 16'h3C3C;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dsave = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstfill.async");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstfill.ready", 32'(bus.cmd_ready), 32'd1);
        check("rstfill.no_done", 32'(done_cnt), 32'(dsave));
        check("rstfill.sb_empty", 32'(sb_q.size()), 32'd0);
        last_addr = 0;
        last_data = 0;
        run_cmd(1'b0, 7, 0, 16'h7777, -1, 1, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 The block SHALL have parameter size, default 2048, meaning number of words in the target memory.
REQ-002 The block SHALL have parameter width, default 16, meaning data word width in bits.
REQ-003 The block SHALL have parameter asize, default $clog2(size), meaning address width.
REQ-004 Port: clk  input  1  single clock; all state changes on posedge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: cmd_valid  input  1  command request.
REQ-007 Port: cmd_ready  output  1  block can accept a command.
REQ-008 Port: cmd_fill  input  1  0 = single-word write, 1 = fill run.
REQ-009 Port: cmd_addr  input  asize  start address.
REQ-010 Port: cmd_len  input  asize+1  fill word count, 0..size; ignored when cmd_fill=0.
REQ-011 Port: cmd_data  input  width  write value.
REQ-012 Port: abort  input  1  terminate an active fill.
REQ-013 Port: we  output  1  memory write enable.
REQ-014 Port: waddr  output  asize  memory write address.
REQ-015 Port: wdata  output  width  memory write data.
REQ-016 Port: busy  output  1  high in any state other than IDLE.
REQ-017 Port: done  output  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, FILL and DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on a clock edge with cmd_valid=1 and cmd_ready=1.
REQ-020 On acceptance, the block SHALL latch cmd_addr, cmd_data and cmd_len, and SHALL NOT sample command inputs again until it returns to IDLE.
REQ-021 IDLE -> WRITE on acceptance with cmd_fill=0; WRITE SHALL last one cycle with we=1, waddr=latched addr and wdata=latched data, then go to DONE.
REQ-022 IDLE -> FILL on acceptance with cmd_fill=1 and cmd_len>0; IDLE -> DONE directly on cmd_fill=1 and cmd_len=0, with no write.
REQ-023 In FILL, each cycle SHALL assert we=1 with wdata=latched data, the address SHALL increment by 1 per write, and a remaining-count SHALL decrement by 1 per write.
REQ-024 Address increment SHALL wrap modulo size (size-1 -> 0, also for non-power-of-2 size).
REQ-025 FILL -> DONE after the cycle that performs the write with remaining-count=1.
REQ-026 If abort=1 in a FILL cycle, that cycle's write SHALL still occur, and FILL -> DONE with no further writes.
REQ-027 abort SHALL be ignored in IDLE, WRITE and DONE.
REQ-028 DONE SHALL last one cycle with done=1 and we=0, then go to IDLE.
REQ-029 Latency: for a command accepted at edge N, the first write SHALL be in cycle N+1, the last write in cycle N+len, done in cycle N+len+1, and cmd_ready SHALL be 1 in cycle N+len+2; for a single write, len counts as 1.
REQ-030 we SHALL be 0 in IDLE and DONE, and waddr/wdata SHALL hold their last values when we=0.
REQ-031 cmd_len > size SHALL be clamped to size.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE immediately, independent of clk.
REQ-033 While rst_n=0: we=0, busy=0, done=0, cmd_ready=0, waddr=0, wdata=0, remaining-count=0.
REQ-034 cmd_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-035 Reset asserted mid-FILL or mid-WRITE SHALL abandon the operation with no further writes and no done pulse.

Verification
REQ-036 Single write: cmd_fill=0, addr=5, data=0xABCD accepted at N -> cycle N+1 we=1, waddr=5, wdata=0xABCD; done at N+2; cmd_ready at N+3.
REQ-037 Fill wrap: size=2048, addr=2046, len=4, data=0x0F0F -> writes to 2046, 2047, 0, 1 in N+1..N+4; done at N+5.
REQ-038 Zero length: cmd_fill=1, len=0 -> no we; done at N+1; cmd_ready at N+2.
REQ-039 Abort: addr=0, len=100, abort pulsed during the 3rd write cycle -> exactly 3 writes (addresses 0, 1, 2), then done the next cycle.
REQ-040 Reset mid-fill: addr=10, len=50, rst_n low for 2 cycles after 5 writes -> we=0 immediately, no done, cmd_ready=1 the first cycle after release; then a single write to 7 succeeds.
REQ-041 Back-to-back: cmd_valid held high with two queued commands -> the second is accepted only when cmd_ready=1 after done, and the two commands' writes never overlap.
